// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / debug) round-robin arbiter in front of a
// single-ported synchronous memory with a fixed read latency.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; arbitrate between cpu_req and dbg_req
// ISSUE | one-cycle grant pulse and memory strobe for the owner
// WAIT  | read in flight; counts MEM_LAT cycles, captures mem_rdata last
// RESP  | one-cycle done pulse to the owner; remember it as last_owner
//
// Every output is a flop. Grant and strobes are loaded on the IDLE->ISSUE
// edge so they are high during ISSUE; done is loaded on the edge into RESP.
module mem_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          cclk,
  input  logic          rstb,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,

  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy,
  output logic          owner,
  output logic [15:0]   cpu_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic          last_owner;
  logic          we_q;
  logic [2:0]    wait_cnt;

  logic          any_req;
  logic          win_dbg;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Pick the winner: a lone requester wins; on a conflict the port that
  // did not own the previous transaction wins.
  always_comb begin
    any_req   = cpu_req | dbg_req;
    win_dbg   = dbg_req & (~cpu_req | ~last_owner);
    win_we    = win_dbg ? dbg_we    : cpu_we;
    win_addr  = win_dbg ? dbg_addr  : cpu_addr;
    win_wdata = win_dbg ? dbg_wdata : cpu_wdata;
  end

  // Transaction sequencer with registered grant, strobe, done and rdata.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      wait_cnt   <= 3'd0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_gnt  <= 1'b0;
      dbg_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            owner     <= win_dbg;
            we_q      <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            cpu_gnt   <= ~win_dbg;
            dbg_gnt   <= win_dbg;
            mem_re    <= ~win_we;
            mem_we    <= win_we;
          end
        end
        ISSUE: begin
          if (we_q) begin
            // Writes complete without waiting on the memory.
            state    <= RESP;
            cpu_done <= ~owner;
            dbg_done <= owner;
          end else begin
            state    <= WAIT;
            wait_cnt <= 3'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            state    <= RESP;
            cpu_done <= ~owner;
            dbg_done <= owner;
            if (owner) begin
              dbg_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          last_owner <= owner;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Count cycles the CPU spent requesting without being granted; saturates.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      cpu_stall_cnt <= 16'd0;
    end else if (cpu_req && !cpu_gnt && (cpu_stall_cnt != 16'hFFFF)) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. The stimulus side runs a
// transaction-level model that predicts grant/done events, read data and the
// CPU stall count; a negedge monitor pops those predictions and compares.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int L  = 3;

  logic          cclk = 1'b0;
  logic          rstb = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          cpu_gnt, cpu_done, dbg_gnt, dbg_done;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy, owner;
  logic [15:0]   cpu_stall_cnt;

  mem_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(L)) dut (
    .cclk(cclk), .rstb(rstb),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .cpu_stall_cnt(cpu_stall_cnt)
  );

  always #5 cclk = ~cclk;

  int cyc = 0;
  always @(posedge cclk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int          cyc;
    bit          done;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cpu_rd;
    logic [31:0] dbg_rd;
  } ev_t;

  ev_t         q[$];
  logic [15:0] stall_at[int];
  bit          gnt_log[$];

  // reference model state
  logic [31:0] mmem[16];
  logic [31:0] m_rd[2];
  bit          m_last;
  int          m_free_at;
  int          m_cpu_gnt_cyc;
  logic [15:0] m_stall;

  // memory behind the DUT
  logic [31:0] tbmem[16];
  bit          pend_v = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_init(input int i);
    return (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory: writes land on the strobe cycle; read data is presented for the
  // whole cycle that is L cycles after mem_re, random garbage otherwise.
  always @(negedge cclk) begin
    if (!rstb) begin
      pend_v = 1'b0;
      mem_rdata = $urandom;
    end else begin
      if (pend_v && pend_due == cyc) begin
        mem_rdata = tbmem[pend_addr[3:0]];
        pend_v = 1'b0;
      end else begin
        mem_rdata = $urandom;
      end
      if (mem_we) tbmem[mem_addr[3:0]] = mem_wdata;
      if (mem_re) begin
        pend_v    = 1'b1;
        pend_due  = cyc + L;
        pend_addr = mem_addr;
      end
    end
  end

  task automatic model_reset();
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_last = 1'b1;
    m_free_at = 0;
    m_cpu_gnt_cyc = -1;
    m_stall = '0;
  endtask

  // One cycle of the reference: inputs for the current cycle are stable.
  task automatic model_step();
    int k = cyc;
    int dcyc;
    bit win;
    bit we;
    ev_t e;
    if (cpu_req && (k != m_cpu_gnt_cyc) && (m_stall != 16'hFFFF)) m_stall++;
    stall_at[k+1] = m_stall;
    if (k >= m_free_at && (cpu_req || dbg_req)) begin
      win = (cpu_req && dbg_req) ? !m_last : dbg_req;
      we  = win ? dbg_we : cpu_we;
      dcyc = we ? k + 2 : k + L + 2;
      e.cyc = k + 1;
      e.done = 1'b0;
      e.port = win;
      e.we = we;
      e.addr = win ? dbg_addr : cpu_addr;
      e.wdata = win ? dbg_wdata : cpu_wdata;
      e.cpu_rd = m_rd[0];
      e.dbg_rd = m_rd[1];
      q.push_back(e);
      if (we) mmem[e.addr[3:0]] = e.wdata;
      else    m_rd[win] = mmem[e.addr[3:0]];
      e.cyc = dcyc;
      e.done = 1'b1;
      e.cpu_rd = m_rd[0];
      e.dbg_rd = m_rd[1];
      q.push_back(e);
      m_last = win;
      m_free_at = dcyc + 1;
      if (!win) m_cpu_gnt_cyc = k + 1;
    end
  endtask

  // Monitor: every strobe must match the oldest predicted event.
  always @(negedge cclk) begin : monitor
    ev_t e;
    logic [5:0] sig;
    logic [5:0] exp_sig;
    int k;
    k = cyc;
    sig = {cpu_gnt, dbg_gnt, cpu_done, dbg_done, mem_re, mem_we};
    while (q.size() > 0 && q[0].cyc < k) begin
      e = q.pop_front();
      n_total++;
      $display("FAIL missed_event: done=%0d port=%0d due cycle %0d not seen (now %0d)",
               e.done, e.port, e.cyc, k);
    end
    if (sig != 6'd0) begin
      if (q.size() == 0 || q[0].cyc != k) begin
        n_total++;
        $display("FAIL unexpected_strobe: got %b, expected none (cycle %0d)", sig, k);
      end else begin
        e = q.pop_front();
        if (!e.done) begin
          exp_sig = {!e.port, e.port, 2'b00, !e.we, e.we};
          gnt_log.push_back(e.port);
          chk("gnt_strobes", 32'(sig), 32'(exp_sig));
          chk("gnt_mem_addr", mem_addr, e.addr);
          chk("gnt_mem_wdata", mem_wdata, e.wdata);
        end else begin
          exp_sig = {2'b00, !e.port, e.port, 2'b00};
          chk("done_strobes", 32'(sig), 32'(exp_sig));
          chk("done_mem_addr_held", mem_addr, e.addr);
        end
        chk("owner", 32'(owner), 32'(e.port));
        chk("busy", 32'(busy), 32'd1);
        chk("cpu_rdata", cpu_rdata, e.cpu_rd);
        chk("dbg_rdata", dbg_rdata, e.dbg_rd);
      end
    end
    if (stall_at.exists(k)) begin
      chk("stall_cnt", 32'(cpu_stall_cnt), 32'(stall_at[k]));
      stall_at.delete(k);
    end
  end

  task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge cclk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    if (rstb) model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic check_zero();
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_dbg_done", 32'(dbg_done), 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy_owner", {30'd0, busy, owner}, 32'd0);
    chk("rst_stall_cnt", 32'(cpu_stall_cnt), 32'd0);
  endtask

  // Pulse rstb low for one cycle, then release with an optional CPU read
  // request already present in the first cycle with rstb high.
  task automatic reset_pulse(input bit cr, input logic [31:0] ca);
    @(posedge cclk);
    #1;
    rstb = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    #1 check_zero();
    q.delete();
    stall_at.delete();
    model_reset();
    @(posedge cclk);
    #1;
    rstb = 1'b1;
    cpu_req = cr; cpu_we = 1'b0; cpu_addr = ca; cpu_wdata = 32'h0;
    model_step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] s0;
    for (int i = 0; i < 16; i++) begin
      tbmem[i] = mem_init(i);
      mmem[i]  = mem_init(i);
    end
    model_reset();
    repeat (2) @(posedge cclk);
    #1 check_zero();
    @(posedge cclk);
    #1 rstb = 1'b1;

    // CPU read of 0x10 returns 0xDEADBEEF
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(L + 4);
    chk("cpu_read_data", cpu_rdata, 32'hDEADBEEF);

    // both held after reset: CPU, DBG, CPU, DBG
    reset_pulse(0, 32'h0);
    gnt_log.delete();
    repeat (4 * (L + 3)) drive(1, 0, 32'h1, 32'h0, 1, 0, 32'h2, 32'h0);
    idle(L + 4);
    chk("rr_count", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) chk("rr_order", 32'(gnt_log[i]), 32'(i % 2));

    // DBG write 0x55 to 0x20 leaves dbg_rdata alone
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h55);
    idle(4);
    chk("dbg_rdata_after_write", dbg_rdata, mmem[2]);

    // DBG read in flight while the CPU waits: six stall cycles
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
    drive(1, 0, 32'h9, 32'h0, 0, 0, 32'h0, 32'h0);
    s0 = cpu_stall_cnt;
    repeat (5) drive(1, 0, 32'h9, 32'h0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 32'h9, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("stall_wait_gnt", 32'(cpu_gnt), 32'd1);
    chk("stall_delta", 32'(cpu_stall_cnt - s0), 32'd6);
    idle(L + 4);

    // randomized traffic with address/data churn every cycle
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 31)), $urandom);
    end
    idle(L + 4);

    // reset during WAIT aborts silently; next CPU request granted a cycle later
    drive(1, 0, 32'h5, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(2);
    reset_pulse(1, 32'h7);
    idle(L + 6);

    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
